// File: rtl/mux_n_seq.sv
// ============================================================================
// Module   : mux_n_seq
// Summary  : N-input Versat routing mux with static/data/sequenced select and
//            a free-running LAT-stage output pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_n_seq #(
    parameter  int DATA_W = 32,
    parameter  int N      = 8,
    parameter  int LAT    = 1,
    parameter  int HOLD_W = 16,
    localparam int SEL_W  = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                running,
    input  logic                run,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0]   in_sel,
    input  logic [1:0]          mode,
    input  logic [SEL_W-1:0]    sel_cfg,
    input  logic [HOLD_W-1:0]   hold,
    output logic [DATA_W-1:0]   out0,
    output logic [SEL_W-1:0]    out_sel,
    output logic                out_valid
);

    localparam int versat_latency = LAT;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_DATA   = 2'd1;
    localparam logic [1:0] MODE_SEQ    = 2'd2;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);
    localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N);

    logic [SEL_W-1:0]  w_idx;
    logic              w_in_range;
    logic              w_legal;
    logic [DATA_W-1:0] w_mux;
    logic              w_unused_sel_hi;

    logic [DATA_W-1:0] stage_data_d;
    logic [SEL_W-1:0]  stage_sel_d;
    logic              stage_valid_d;

    logic [DATA_W-1:0] data_q  [versat_latency];
    logic [SEL_W-1:0]  sel_q   [versat_latency];
    logic              valid_q [versat_latency];

    logic [SEL_W-1:0]  seq_idx_d,   seq_idx_q;
    logic [HOLD_W-1:0] dwell_cnt_d, dwell_cnt_q;

    assign w_unused_sel_hi = ^in_sel[DATA_W-1:SEL_W];

    // Mode 3 forces index 0 so the reported out_sel is 0 while disabled.
    always_comb begin
        w_idx = '0;
        case (mode)
            MODE_STATIC: w_idx = sel_cfg;
            MODE_DATA:   w_idx = in_sel[SEL_W-1:0];
            MODE_SEQ:    w_idx = seq_idx_q;
            default:     w_idx = '0;
        endcase
    end

    generate
        if ((1 << SEL_W) == N) begin : g_range_full
            assign w_in_range = 1'b1;
        end else begin : g_range_part
            assign w_in_range = ({1'b0, w_idx} < N_EXT);
        end
    endgenerate

    assign w_legal = w_in_range && (mode != 2'd3);

    always_comb begin
        w_mux = '0;
        for (int i = 0; i < N; i++) begin
            if (w_idx == SEL_W'(i)) begin
                w_mux = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        stage_data_d  = w_legal ? w_mux : '0;
        stage_sel_d   = w_idx;
        stage_valid_d = w_legal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < versat_latency; s++) begin
                data_q[s]  <= '0;
                sel_q[s]   <= '0;
                valid_q[s] <= 1'b0;
            end
        end else begin
            data_q[0]  <= stage_data_d;
            sel_q[0]   <= stage_sel_d;
            valid_q[0] <= stage_valid_d;
            for (int s = 1; s < versat_latency; s++) begin
                data_q[s]  <= data_q[s-1];
                sel_q[s]   <= sel_q[s-1];
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    assign out0      = data_q[versat_latency-1];
    assign out_sel   = sel_q[versat_latency-1];
    assign out_valid = valid_q[versat_latency-1];

    // A hold lowered below the running dwell count wraps through HOLD_W.
    always_comb begin
        seq_idx_d   = seq_idx_q;
        dwell_cnt_d = dwell_cnt_q;
        if (run) begin
            seq_idx_d   = '0;
            dwell_cnt_d = '0;
        end else if (running && (mode == MODE_SEQ)) begin
            if (dwell_cnt_q == hold) begin
                dwell_cnt_d = '0;
                seq_idx_d   = (seq_idx_q == LAST_IDX) ? '0 : seq_idx_q + 1'b1;
            end else begin
                dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_idx_q   <= '0;
            dwell_cnt_q <= '0;
        end else begin
            seq_idx_q   <= seq_idx_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mux_n_seq.sv
// ============================================================================
// Module   : tb_mux_n_seq
// Summary  : Directed self-checking bench for mux_n_seq across three configs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux_n_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance a: N=8, LAT=2 (static and data-driven modes)
    logic          running_a = 1'b0, run_a = 1'b0;
    logic [255:0]  in_data_a;
    logic [31:0]   in_sel_a = '0;
    logic [1:0]    mode_a = 2'd0;
    logic [2:0]    sel_cfg_a = 3'd5;
    logic [15:0]   hold_a = '0;
    logic [31:0]   out0_a;
    logic [2:0]    out_sel_a;
    logic          out_valid_a;

    // Instance b: N=4, LAT=3 (sequencer and reset)
    logic          running_b = 1'b0, run_b = 1'b0;
    logic [127:0]  in_data_b;
    logic [31:0]   in_sel_b = '0;
    logic [1:0]    mode_b = 2'd0;
    logic [1:0]    sel_cfg_b = 2'd0;
    logic [15:0]   hold_b = '0;
    logic [31:0]   out0_b;
    logic [1:0]    out_sel_b;
    logic          out_valid_b;

    // Instance c: N=6, LAT=1 (illegal indices)
    logic          running_c = 1'b0, run_c = 1'b0;
    logic [191:0]  in_data_c;
    logic [31:0]   in_sel_c = '0;
    logic [1:0]    mode_c = 2'd1;
    logic [2:0]    sel_cfg_c = 3'd0;
    logic [15:0]   hold_c = '0;
    logic [31:0]   out0_c;
    logic [2:0]    out_sel_c;
    logic          out_valid_c;

    mux_n_seq #(.DATA_W(32), .N(8), .LAT(2), .HOLD_W(16)) u_a (
        .clk(clk), .rst(rst), .running(running_a), .run(run_a),
        .in_data(in_data_a), .in_sel(in_sel_a), .mode(mode_a),
        .sel_cfg(sel_cfg_a), .hold(hold_a),
        .out0(out0_a), .out_sel(out_sel_a), .out_valid(out_valid_a)
    );

    mux_n_seq #(.DATA_W(32), .N(4), .LAT(3), .HOLD_W(16)) u_b (
        .clk(clk), .rst(rst), .running(running_b), .run(run_b),
        .in_data(in_data_b), .in_sel(in_sel_b), .mode(mode_b),
        .sel_cfg(sel_cfg_b), .hold(hold_b),
        .out0(out0_b), .out_sel(out_sel_b), .out_valid(out_valid_b)
    );

    mux_n_seq #(.DATA_W(32), .N(6), .LAT(1), .HOLD_W(16)) u_c (
        .clk(clk), .rst(rst), .running(running_c), .run(run_c),
        .in_data(in_data_c), .in_sel(in_sel_c), .mode(mode_c),
        .sel_cfg(sel_cfg_c), .hold(hold_c),
        .out0(out0_c), .out_sel(out_sel_c), .out_valid(out_valid_c)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int        data_sel_tab [4]  = '{0, 3, 7, 2};
    logic [31:0] data_exp_tab [4] = '{32'h000, 32'h300, 32'h700, 32'h200};
    int        seq_pat    [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int        freeze_pat [5]  = '{0, 0, 1, 1, 1};
    int        resume_pat [12] = '{1, 1, 1, 1, 1, 2, 2, 2, 0, 0, 0, 1};

    initial begin
        for (int i = 0; i < 8; i++) in_data_a[i*32 +: 32] = 32'h100 * i;
        for (int i = 0; i < 4; i++) in_data_b[i*32 +: 32] = 32'h10 + i;
        for (int i = 0; i < 6; i++) in_data_c[i*32 +: 32] = 32'h100 * i + 32'h11;

        tick();
        tick();
        check_val("rst_out0_a",  out0_a, 0);
        check_val("rst_sel_a",   out_sel_a, 0);
        check_val("rst_valid_a", out_valid_a, 0);
        check_val("rst_out0_b",  out0_b, 0);
        check_val("rst_valid_b", out_valid_b, 0);
        check_val("rst_valid_c", out_valid_c, 0);
        rst = 1'b0;

        // Static mode: input 5 ramps, output trails by two cycles
        for (int t = 0; t < 8; t++) begin
            in_data_a[5*32 +: 32] = 32'hA0 + t;
            tick();
            if (t >= 1) begin
                check_val("static_out0",  out0_a, 32'hA0 + t - 1);
                check_val("static_sel",   out_sel_a, 5);
                check_val("static_valid", out_valid_a, 1);
            end
        end
        in_data_a[5*32 +: 32] = 32'h500;

        // Data-driven mode
        mode_a = 2'd1;
        for (int j = 0; j < 5; j++) begin
            if (j < 4) in_sel_a = data_sel_tab[j];
            tick();
            if (j >= 1) begin
                check_val("data_out0",  out0_a, data_exp_tab[j-1]);
                check_val("data_sel",   out_sel_a, data_sel_tab[j-1]);
                check_val("data_valid", out_valid_a, 1);
            end
        end

        // Illegal indices on N=6, LAT=1
        in_sel_c = 32'd7;
        tick();
        check_val("ill7_out0",  out0_c, 0);
        check_val("ill7_sel",   out_sel_c, 7);
        check_val("ill7_valid", out_valid_c, 0);
        in_sel_c = 32'd6;
        tick();
        check_val("ill6_sel",   out_sel_c, 6);
        check_val("ill6_valid", out_valid_c, 0);
        in_sel_c = 32'd5;
        tick();
        check_val("last_out0",  out0_c, 32'h511);
        check_val("last_valid", out_valid_c, 1);
        in_sel_c = 32'hFFFF_FFF9;
        tick();
        check_val("hibits_out0", out0_c, 32'h111);
        check_val("hibits_sel",  out_sel_c, 1);
        mode_c = 2'd3;
        tick();
        check_val("off_out0",  out0_c, 0);
        check_val("off_sel",   out_sel_c, 0);
        check_val("off_valid", out_valid_c, 0);

        // Sequencer: N=4, hold=2, LAT=3
        mode_b = 2'd2;
        hold_b = 16'd2;
        run_b  = 1'b1;
        tick();
        run_b     = 1'b0;
        running_b = 1'b1;
        for (int j = 0; j < 15; j++) begin
            tick();
            if (j >= 2) begin
                check_val("seq_sel",   out_sel_b, seq_pat[j-2]);
                check_val("seq_out0",  out0_b, 32'h10 + seq_pat[j-2]);
                check_val("seq_valid", out_valid_b, 1);
            end
        end
        running_b = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            check_val("freeze_sel", out_sel_b, freeze_pat[j]);
        end
        running_b = 1'b1;
        for (int r = 0; r < 12; r++) begin
            run_b = (r == 5);
            tick();
            check_val("resume_sel",  out_sel_b, resume_pat[r]);
            check_val("resume_out0", out0_b, 32'h10 + resume_pat[r]);
        end
        run_b = 1'b0;

        // Asynchronous reset mid-stream, between clock edges
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_out0_b",  out0_b, 0);
        check_val("arst_sel_b",   out_sel_b, 0);
        check_val("arst_valid_b", out_valid_b, 0);
        check_val("arst_valid_a", out_valid_a, 0);
        tick();
        rst       = 1'b0;
        running_b = 1'b0;
        mode_b    = 2'd0;
        sel_cfg_b = 2'd1;
        tick();
        check_val("post_rst_v1", out_valid_b, 0);
        tick();
        check_val("post_rst_v2", out_valid_b, 0);
        tick();
        check_val("post_rst_v3",   out_valid_b, 1);
        check_val("post_rst_out0", out0_b, 32'h11);
        check_val("post_rst_sel",  out_sel_b, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
